fft_output_reorder: RTL and testbench
=====================================

Name: fft_output_reorder

Overview:
- Reader side of the radix-2 FFT sample interface.
- Captures one frame of 2**log2Ns results, which the FFT core emits one per strobe in bit-reversed index order.
- Stores each result at its bit-reversed address, then streams the frame downstream in natural order over a valid/ready handshake.
- Sits directly after fft_radix2_real, ahead of magnitude/peak logic.

Parameters:
log2Ns, 10, log2(frame length N); legal range 1..12
Nbits, 8, bits per sample, carried through unmodified

Ports:
clk  input  1  single clock; all logic rising-edge
rst  input  1  synchronous, active-high reset
fft_samples  input  Nbits  FFT result word, valid when fft_valid=1
fft_valid  input  1  strobe: one result per high cycle
fft_ready  output  1  high while block accepts results (CAPTURE state)
dout  output  Nbits  reordered sample, natural index order
dout_valid  output  1  dout holds a valid sample
dout_ready  input  1  downstream accepts dout this cycle
dout_last  output  1  high with dout_valid on natural index N-1
idle  output  1  CAPTURE state with zero samples captured
overrun  output  1  sticky: fft_valid seen while fft_ready=0

Behaviour:
- Reset (rst=1 at clk edge): state CAPTURE, wr_cnt=0, rd_cnt=0, dout_valid=0, dout_last=0, dout=0, overrun=0, fft_ready=1, idle=1. Buffer contents are not cleared. Reset mid-capture or mid-drain abandons the frame; no partial output.
- States: CAPTURE, DRAIN.
- CAPTURE: fft_ready=1.
  - Each cycle with fft_valid=1: mem[bitrev(wr_cnt)] <= fft_samples, wr_cnt++.
  - bitrev reverses the log2Ns bits of wr_cnt; e.g. N=8, wr_cnt 1 -> addr 4, 3 -> addr 6.
  - Accepting sample with wr_cnt=N-1 in cycle T: wr_cnt wraps to 0, state becomes DRAIN at T+1. fft_ready=0 from T+1.
- DRAIN: fft_ready=0.
  - First dout_valid=1 at cycle T+2 with dout=mem[0] (fixed 1-cycle read latency).
  - Handshake = dout_valid & dout_ready. Each handshake advances rd_cnt. The next sample is presented the following cycle with no bubble: sustained throughput 1 sample/cycle while dout_ready=1.
  - dout_valid=1 and dout_ready=0: dout, dout_last and dout_valid hold stable.
  - dout_valid never drops until its sample is accepted.
  - dout_last=1 only while dout presents natural index N-1.
  - Handshake on index N-1 in cycle U: dout_valid=0 and dout_last=0 at U+1; state CAPTURE, fft_ready=1, idle=1 at U+1. rd_cnt wraps to 0.
- overrun: set on any cycle with fft_valid=1 and fft_ready=0. The sample is dropped and does not alter buffer or counters. Cleared only by rst.
- idle = (state==CAPTURE) & (wr_cnt==0). Combinational from registered state.
- fft_valid in the same cycle fft_ready first rises (U+1) is accepted normally.
- Buffer: single-port-per-direction memory of N x Nbits, synchronous read. Inferable as block RAM.
- log2Ns=1: bitrev is identity; order unchanged.

Test Plan:
1. log2Ns=3, Nbits=8: feed 0,1,...,7 back-to-back with dout_ready=1 -> dout sequence 0,4,2,6,1,5,3,7 on consecutive cycles. First dout_valid 2 cycles after last fft_valid; dout_last only on 7.
2. Same frame, dout_ready pattern 1,0,0,1,0,1... -> identical sequence; dout/dout_last stable during every stall; no duplicates or drops.
3. Pulse fft_valid with 0xAA while in DRAIN -> overrun=1 and stays 1. Output frame unchanged; next frame captures correctly.
4. Assert rst after 5 of 8 samples captured -> next cycle fft_ready=1, idle=1, dout_valid=0. A fresh 8-sample frame reorders correctly, with no residue from the aborted frame.
5. Two frames back-to-back, second frame's first fft_valid in the cycle after dout_last handshake -> accepted. Outputs reorder independently; overrun stays 0.
6. log2Ns=1: feed 0x12,0x34 -> dout 0x12 then 0x34 with dout_last on 0x34.

Source files
------------

// File: rtl/fft_output_reorder.sv
// Collects one bit-reversed FFT frame into a buffer, then streams it out in
// natural index order over a valid/ready handshake.
module fft_output_reorder #(
  parameter int unsigned log2Ns = 10,
  parameter int unsigned Nbits  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [Nbits-1:0] fft_samples,
  input  logic             fft_valid,
  output logic             fft_ready,
  output logic [Nbits-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             dout_last,
  output logic             idle,
  output logic             overrun
);

  localparam int unsigned N = 1 << log2Ns;
  localparam logic [log2Ns-1:0] LAST_IDX = {log2Ns{1'b1}};

  typedef enum logic {
    CAPTURE = 1'b0,
    DRAIN   = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [log2Ns-1:0] wr_cnt_q, wr_cnt_d;
  logic [log2Ns-1:0] rd_cnt_q, rd_cnt_d;
  logic              dout_valid_q, dout_valid_d;
  logic              dout_last_q, dout_last_d;
  logic              overrun_q, overrun_d;
  logic [Nbits-1:0]  dout_q;
  logic              wr_en_c;
  logic              rd_en_c;
  logic [log2Ns-1:0] wr_addr_c;

  logic [Nbits-1:0] mem [N];

  function automatic logic [log2Ns-1:0] bitrev(input logic [log2Ns-1:0] x);
    logic [log2Ns-1:0] r;
    for (int i = 0; i < int'(log2Ns); i++) begin
      r[i] = x[int'(log2Ns) - 1 - i];
    end
    return r;
  endfunction

  // Next-state, counters and handshake control
  always_comb begin
    state_d      = state_q;
    wr_cnt_d     = wr_cnt_q;
    rd_cnt_d     = rd_cnt_q;
    dout_valid_d = dout_valid_q;
    dout_last_d  = dout_last_q;
    overrun_d    = overrun_q | (fft_valid & (state_q != CAPTURE));
    wr_en_c      = 1'b0;
    rd_en_c      = 1'b0;
    wr_addr_c    = bitrev(wr_cnt_q);

    case (state_q)
      CAPTURE: begin
        if (fft_valid) begin
          wr_en_c  = 1'b1;
          wr_cnt_d = wr_cnt_q + log2Ns'(1);
          if (wr_cnt_q == LAST_IDX) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (dout_valid_q && dout_ready) begin
          if (dout_last_q) begin
            state_d      = CAPTURE;
            dout_valid_d = 1'b0;
            dout_last_d  = 1'b0;
          end else begin
            rd_en_c = 1'b1;
          end
        end else if (!dout_valid_q) begin
          rd_en_c = 1'b1;
        end
        // Read pointer runs one ahead of the sample on dout
        if (rd_en_c) begin
          rd_cnt_d     = rd_cnt_q + log2Ns'(1);
          dout_valid_d = 1'b1;
          dout_last_d  = (rd_cnt_q == LAST_IDX);
        end
      end
      default: state_d = CAPTURE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= CAPTURE;
      wr_cnt_q     <= '0;
      rd_cnt_q     <= '0;
      dout_valid_q <= 1'b0;
      dout_last_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_cnt_q     <= wr_cnt_d;
      rd_cnt_q     <= rd_cnt_d;
      dout_valid_q <= dout_valid_d;
      dout_last_q  <= dout_last_d;
      overrun_q    <= overrun_d;
    end
  end

  // Frame buffer: write port, contents survive reset
  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      mem[wr_addr_c] <= fft_samples;
    end
  end

  // Synchronous read port doubles as the output data register
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q <= '0;
    end else if (rd_en_c) begin
      dout_q <= mem[rd_cnt_q];
    end
  end

  assign fft_ready  = (state_q == CAPTURE);
  assign idle       = (state_q == CAPTURE) && (wr_cnt_q == '0);
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign dout_last  = dout_last_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_fft_output_reorder.sv
// Directed bench for fft_output_reorder: an N=8 instance checked through an
// output scoreboard, plus an N=2 instance checked cycle by cycle.
module tb_fft_output_reorder;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] fft_samples;
  logic       fft_valid;
  logic       fft_ready;
  logic [7:0] dout;
  logic       dout_valid;
  logic       dout_ready;
  logic       dout_last;
  logic       idle;
  logic       overrun;

  logic [7:0] fft_samples_1;
  logic       fft_valid_1;
  logic       fft_ready_1;
  logic [7:0] dout_1;
  logic       dout_valid_1;
  logic       dout_ready_1;
  logic       dout_last_1;
  logic       idle_1;
  logic       overrun_1;

  int n_vec = 0;
  int n_err = 0;

  logic [8:0] exp_q [$];
  logic [8:0] exp_e;
  logic       stall_seen = 1'b0;
  logic [8:0] held;
  logic [7:0] v [8];
  logic [5:0] ready_pat = 6'b101001;

  fft_output_reorder #(.log2Ns(3), .Nbits(8)) dut8 (
    .clk(clk), .rst(rst), .fft_samples(fft_samples), .fft_valid(fft_valid),
    .fft_ready(fft_ready), .dout(dout), .dout_valid(dout_valid),
    .dout_ready(dout_ready), .dout_last(dout_last), .idle(idle), .overrun(overrun)
  );

  fft_output_reorder #(.log2Ns(1), .Nbits(8)) dut2 (
    .clk(clk), .rst(rst), .fft_samples(fft_samples_1), .fft_valid(fft_valid_1),
    .fft_ready(fft_ready_1), .dout(dout_1), .dout_valid(dout_valid_1),
    .dout_ready(dout_ready_1), .dout_last(dout_last_1), .idle(idle_1),
    .overrun(overrun_1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int br3(input int n);
    logic [2:0] x;
    x = n[2:0];
    return int'({x[0], x[1], x[2]});
  endfunction

  // Output monitor: pops the scoreboard on every handshake, checks stall hold
  always @(negedge clk) begin
    if (rst) begin
      stall_seen = 1'b0;
    end else begin
      if (stall_seen) begin
        check("stall_hold", {23'd0, dout_valid, dout_last, dout}, {23'd0, 1'b1, held});
      end
      if (dout_valid && dout_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", 32'(dout_valid), 32'd0);
        end else begin
          exp_e = exp_q.pop_front();
          check("dout", 32'(dout), 32'(exp_e[7:0]));
          check("dout_last", 32'(dout_last), 32'(exp_e[8]));
        end
      end
      stall_seen = dout_valid && !dout_ready;
      held       = {dout_last, dout};
    end
  end

  task automatic feed(input logic [7:0] vals [8]);
    for (int n = 0; n < 8; n++) begin
      exp_q.push_back({(n == 7), vals[br3(n)]});
    end
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      fft_valid   = 1'b1;
      fft_samples = vals[k];
    end
    @(posedge clk); #1;
    fft_valid = 1'b0;
  endtask

  task automatic drain(input bit stall_pat, input int inject_at);
    for (int c = 0; c < 200 && exp_q.size() != 0; c++) begin
      dout_ready = stall_pat ? ready_pat[c % 6] : 1'b1;
      if (c == inject_at) begin
        fft_valid   = 1'b1;
        fft_samples = 8'hAA;
      end else begin
        fft_valid = 1'b0;
      end
      @(posedge clk); #1;
    end
    fft_valid  = 1'b0;
    dout_ready = 1'b1;
    check("drain_timeout", 32'(exp_q.size()), 32'd0);
    check("back_to_capture", {30'd0, fft_ready, idle}, 32'd3);
    check("valid_drops", 32'(dout_valid), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    fft_samples = '0; fft_valid = 1'b0; dout_ready = 1'b1;
    fft_samples_1 = '0; fft_valid_1 = 1'b0; dout_ready_1 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", {26'd0, fft_ready, idle, dout_valid, dout_last, overrun, 1'b0},
          {26'd0, 6'b110000});
    check("reset_dout", 32'(dout), 32'd0);
    rst = 1'b0;

    // Natural ramp: expect 0,4,2,6,1,5,3,7 and two-cycle first-output latency
    for (int k = 0; k < 8; k++) v[k] = 8'(k);
    feed(v);
    check("ready_low_in_drain", 32'(fft_ready), 32'd0);
    check("no_early_valid", 32'(dout_valid), 32'd0);
    @(posedge clk); #1;
    check("first_valid_latency", 32'(dout_valid), 32'd1);
    check("first_dout", 32'(dout), 32'd0);
    drain(1'b0, -1);

    // Same frame under a stalling consumer
    feed(v);
    drain(1'b1, -1);

    // Different data, stray strobe during drain
    for (int k = 0; k < 8; k++) v[k] = 8'h10 + 8'(k * 23);
    feed(v);
    drain(1'b0, 3);
    check("overrun_set", 32'(overrun), 32'd1);
    for (int k = 0; k < 8; k++) v[k] = 8'hF0 - 8'(k * 7);
    feed(v);
    drain(1'b0, -1);
    check("overrun_sticky", 32'(overrun), 32'd1);

    // Abort a partial frame with reset
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      fft_valid   = 1'b1;
      fft_samples = 8'hC0 + 8'(k);
    end
    @(posedge clk); #1;
    fft_valid = 1'b0;
    check("idle_mid_capture", 32'(idle), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("after_abort", {29'd0, fft_ready, idle, dout_valid}, 32'd6);
    check("overrun_cleared", 32'(overrun), 32'd0);
    for (int k = 0; k < 8; k++) v[k] = 8'h31 + 8'(k * 5);
    feed(v);
    drain(1'b0, -1);

    // Back-to-back frames: second frame starts the cycle after the last handshake
    for (int k = 0; k < 8; k++) v[k] = 8'h80 | 8'(k);
    feed(v);
    repeat (8) @(posedge clk);
    for (int k = 0; k < 8; k++) v[k] = 8'h50 + 8'(k * 11);
    feed(v);
    drain(1'b0, -1);
    check("overrun_stays_low", 32'(overrun), 32'd0);

    // Two-sample frame: bit reversal is the identity
    @(posedge clk); #1;
    fft_valid_1 = 1'b1; fft_samples_1 = 8'h12;
    @(posedge clk); #1;
    fft_samples_1 = 8'h34;
    @(posedge clk); #1;
    fft_valid_1 = 1'b0;
    check("n2_no_early_valid", 32'(dout_valid_1), 32'd0);
    @(posedge clk); #1;
    check("n2_first", {22'd0, dout_valid_1, dout_last_1, dout_1}, {22'd0, 2'b10, 8'h12});
    @(posedge clk); #1;
    check("n2_second", {22'd0, dout_valid_1, dout_last_1, dout_1}, {22'd0, 2'b11, 8'h34});
    @(posedge clk); #1;
    check("n2_done", {29'd0, dout_valid_1, fft_ready_1, idle_1}, 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
